// File: rtl/i2c_reg16_slave.sv
// I2C slave exposing a 16-bit register space: 16-bit big-endian address pointer,
// 16-bit data words, auto-increment by 2 on every completed word.
// SCL/SDA are synchronised and glitch-filtered; all protocol logic runs on filtered levels.
module i2c_reg16_slave #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h10,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        busy
);

    localparam int unsigned CntW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    typedef enum logic [3:0] {
        StIdle, StDev, StDevAck, StRaHi, StRaLo, StWHi, StWLo,
        StRHi, StRLo, StSlvAck, StMstAck, StIgnore
    } state_e;

    logic [1:0]          scl_sync_q, sda_sync_q;
    logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
    logic [CntW-1:0]     ready_cnt_q;
    logic                bus_ok_q;

    state_e      state_q, nxt_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  sh_q;
    logic [7:0]  wd_hi_q;
    logic [15:0] tx_q, ptr_q;
    logic        rw_q, rd_lo_q;
    logic        sda_oe_q, wr_en_q, rd_req_q, busy_q;
    logic [15:0] wr_addr_q, wr_data_q, rd_addr_q;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    // START is ignored until the bus has been seen idle after reset.
    assign start_det = bus_ok_q & scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
    assign rx_byte   = {sh_q, sda_f_q};

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;

    // Two-flop synchronisers followed by a FILT_LEN-deep majority-free level filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= FILT_LEN'({scl_hist_q, scl_sync_q[1]});
            sda_hist_q <= FILT_LEN'({sda_hist_q, sda_sync_q[1]});
            if (&scl_hist_q) begin
                scl_f_q <= 1'b1;
            end else if (~|scl_hist_q) begin
                scl_f_q <= 1'b0;
            end
            if (&sda_hist_q) begin
                sda_f_q <= 1'b1;
            end else if (~|sda_hist_q) begin
                sda_f_q <= 1'b0;
            end
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    // Arm START detection once filtered SCL and SDA have both been high for FILT_LEN clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_cnt_q <= '0;
            bus_ok_q    <= 1'b0;
        end else if (!bus_ok_q) begin
            if (scl_f_q && sda_f_q) begin
                if (ready_cnt_q == CntW'(FILT_LEN - 1)) begin
                    bus_ok_q <= 1'b1;
                end else begin
                    ready_cnt_q <= ready_cnt_q + 1'b1;
                end
            end else begin
                ready_cnt_q <= '0;
            end
        end
    end

    // Protocol FSM with registered outputs; bits sampled on SCL rise, SDA driven after SCL fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            nxt_q     <= StIdle;
            bit_cnt_q <= 3'd0;
            sh_q      <= 7'd0;
            wd_hi_q   <= 8'd0;
            tx_q      <= 16'd0;
            ptr_q     <= 16'd0;
            rw_q      <= 1'b0;
            rd_lo_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 16'd0;
            rd_addr_q <= 16'd0;
        end else begin
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            // Read data arrives one clock after the request; SCL is far slower, so no shift collides.
            if (rd_req_q) begin
                tx_q <= rd_data;
            end
            if (start_det) begin
                state_q   <= StDev;
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= StIdle;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        sda_oe_q <= 1'b0;
                    end
                    StDev, StRaHi, StRaLo, StWHi, StWLo: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                        end
                        if (scl_rise) begin
                            sh_q      <= rx_byte[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StSlvAck;
                                case (state_q)
                                    StDev: begin
                                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                                            state_q <= StDevAck;
                                            rw_q    <= rx_byte[0];
                                            busy_q  <= 1'b1;
                                        end else begin
                                            state_q <= StIgnore;
                                            busy_q  <= 1'b0;
                                        end
                                    end
                                    StRaHi: begin
                                        ptr_q[15:8] <= rx_byte;
                                        nxt_q       <= StRaLo;
                                    end
                                    StRaLo: begin
                                        ptr_q[7:0] <= rx_byte;
                                        nxt_q      <= StWHi;
                                    end
                                    StWHi: begin
                                        wd_hi_q <= rx_byte;
                                        nxt_q   <= StWLo;
                                    end
                                    default: begin
                                        wr_en_q   <= 1'b1;
                                        wr_addr_q <= ptr_q;
                                        wr_data_q <= {wd_hi_q, rx_byte};
                                        ptr_q     <= ptr_q + 16'd2;
                                        nxt_q     <= StWHi;
                                    end
                                endcase
                            end
                        end
                    end
                    // ACK slot: pull SDA on the fall after bit 8, leave on the 9th rise.
                    StDevAck, StSlvAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b1;
                        end
                        if (scl_rise) begin
                            bit_cnt_q <= 3'd0;
                            if (state_q == StSlvAck) begin
                                state_q <= nxt_q;
                            end else if (rw_q) begin
                                state_q   <= StRHi;
                                rd_lo_q   <= 1'b0;
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= ptr_q;
                            end else begin
                                state_q <= StRaHi;
                            end
                        end
                    end
                    StRHi, StRLo: begin
                        if (scl_fall) begin
                            sda_oe_q <= ~tx_q[15];
                        end
                        if (scl_rise) begin
                            tx_q      <= {tx_q[14:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StMstAck;
                                rd_lo_q <= (state_q == StRHi);
                                if (state_q == StRLo) begin
                                    ptr_q <= ptr_q + 16'd2;
                                end
                            end
                        end
                    end
                    StMstAck: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                        end
                        if (scl_rise) begin
                            bit_cnt_q <= 3'd0;
                            if (sda_f_q) begin
                                state_q <= StIgnore;
                            end else if (rd_lo_q) begin
                                state_q <= StRLo;
                            end else begin
                                state_q   <= StRHi;
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= ptr_q;
                            end
                        end
                    end
                    StIgnore: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= StIdle;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg16_slave.sv
// Scoreboard bench for i2c_reg16_slave: a bit-banged I2C master drives the bus,
// expected strobes and bus responses are queued, and a negedge monitor checks them.
module tb_i2c_reg16_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [15:0] rd_data = 16'd0;
    logic        sda_bus;
    logic        sda_oe, wr_en, rd_req, busy;
    logic [15:0] wr_addr, wr_data, rd_addr;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = m_sda & ~sda_oe;

    i2c_reg16_slave dut (
        .clk     (clk),
        .rst     (rst),
        .scl_i   (m_scl),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_bus[$];
    logic [15:0] obs_bus[$];
    logic        oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop an expectation whenever the DUT strobes or the master records a bus result.
    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (!rst && wr_en) begin
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wr_en unexpected: got addr 0x%0h data 0x%0h, expected none",
                         wr_addr, wr_data);
            end else begin
                check("wr_en addr/data", {wr_addr, wr_data}, exp_wr.pop_front());
            end
        end
        if (!rst && rd_req) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_req unexpected: got addr 0x%0h, expected none", rd_addr);
            end else begin
                check("rd_req addr", {16'd0, rd_addr}, {16'd0, exp_rd.pop_front()});
            end
        end
        while (obs_bus.size() > 0) begin
            if (exp_bus.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL bus result unexpected: got 0x%0h, expected none", obs_bus[0]);
                void'(obs_bus.pop_front());
            end else begin
                check("bus ack/byte", {16'd0, obs_bus.pop_front()}, {16'd0, exp_bus.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        tick(4);
        m_sda = b;
        tick(12);
        m_scl = 1'b1;
        tick(16);
        m_scl = 1'b0;
    endtask

    task automatic rbit(output logic b);
        tick(4);
        m_sda = 1'b1;
        tick(12);
        m_scl = 1'b1;
        tick(8);
        b = sda_bus;
        tick(8);
        m_scl = 1'b0;
    endtask

    // Result tags: 0xA0xx = ACK seen (1) / not seen (0), 0xB0xx = byte read from slave.
    task automatic wbyte(input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        exp_bus.push_back({8'hA0, 7'd0, exp_ack});
        obs_bus.push_back({8'hA0, 7'd0, ~a});
    endtask

    task automatic rbyte(input logic [7:0] exp_d, input logic ack);
        logic [7:0] d;
        logic       b;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            d = {d[6:0], b};
        end
        exp_bus.push_back({8'hB0, exp_d});
        obs_bus.push_back({8'hB0, d});
        wbit(~ack);
    endtask

    task automatic i2c_start();
        if (!m_scl) begin
            tick(4);
            m_sda = 1'b1;
            tick(12);
            m_scl = 1'b1;
            tick(8);
        end
        m_sda = 1'b0;
        tick(8);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(4);
        m_sda = 1'b0;
        tick(12);
        m_scl = 1'b1;
        tick(8);
        m_sda = 1'b1;
        tick(16);
    endtask

    initial begin
        logic b;
        // Reset state
        tick(3);
        check("reset sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset wr_en", {31'd0, wr_en}, 32'd0);
        check("reset rd_req", {31'd0, rd_req}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset wr_addr", {16'd0, wr_addr}, 32'd0);
        check("reset wr_data", {16'd0, wr_data}, 32'd0);
        check("reset rd_addr", {16'd0, rd_addr}, 32'd0);
        rst = 1'b0;
        tick(20);

        // Single word write 0x10DC to 0x301A
        i2c_start();
        wbyte(8'h20, 1'b1);
        wbyte(8'h30, 1'b1);
        wbyte(8'h1A, 1'b1);
        wbyte(8'h10, 1'b1);
        exp_wr.push_back({16'h301A, 16'h10DC});
        wbyte(8'hDC, 1'b1);
        check("busy mid-transaction", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("busy after STOP", {31'd0, busy}, 32'd0);

        // Set pointer 0x3000, repeated START, read 0x0554
        rd_data = 16'h0554;
        i2c_start();
        wbyte(8'h20, 1'b1);
        wbyte(8'h30, 1'b1);
        wbyte(8'h00, 1'b1);
        exp_rd.push_back(16'h3000);
        i2c_start();
        wbyte(8'h21, 1'b1);
        rbyte(8'h05, 1'b1);
        rbyte(8'h54, 1'b0);
        i2c_stop();

        // Burst write of two words from 0x302C
        exp_wr.push_back({16'h302C, 16'h0001});
        exp_wr.push_back({16'h302E, 16'h0008});
        i2c_start();
        wbyte(8'h20, 1'b1);
        wbyte(8'h30, 1'b1);
        wbyte(8'h2C, 1'b1);
        wbyte(8'h00, 1'b1);
        wbyte(8'h01, 1'b1);
        wbyte(8'h00, 1'b1);
        wbyte(8'h08, 1'b1);
        i2c_stop();

        // Foreign address: no ACK, SDA never pulled, not busy
        oe_seen = 1'b0;
        i2c_start();
        wbyte(8'h22, 1'b0);
        check("busy after foreign address", {31'd0, busy}, 32'd0);
        wbyte(8'h55, 1'b0);
        i2c_stop();
        check("sda_oe seen during foreign address", {31'd0, oe_seen}, 32'd0);

        // STOP after 4 bits of the low data byte: no write
        i2c_start();
        wbyte(8'h20, 1'b1);
        wbyte(8'h12, 1'b1);
        wbyte(8'h34, 1'b1);
        wbyte(8'hAB, 1'b1);
        wbit(1'b1);
        wbit(1'b1);
        wbit(1'b0);
        wbit(1'b0);
        i2c_stop();
        exp_wr.push_back({16'h4000, 16'h1234});
        i2c_start();
        wbyte(8'h20, 1'b1);
        wbyte(8'h40, 1'b1);
        wbyte(8'h00, 1'b1);
        wbyte(8'h12, 1'b1);
        wbyte(8'h34, 1'b1);
        i2c_stop();

        // Reset in the middle of a read while the slave pulls SDA low
        rd_data = 16'hBEEF;
        exp_rd.push_back(16'h4002);
        i2c_start();
        wbyte(8'h21, 1'b1);
        rbit(b);
        check("read bit15 before reset", {31'd0, b}, 32'd1);
        tick(12);
        check("sda_oe driving bit14", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check("sda_oe after async reset", {31'd0, sda_oe}, 32'd0);
        check("busy after async reset", {31'd0, busy}, 32'd0);
        tick(2);
        m_sda = 1'b1;
        m_scl = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);

        // Pointer back to 0 after reset; normal transaction accepted
        rd_data = 16'h1357;
        exp_rd.push_back(16'h0000);
        i2c_start();
        wbyte(8'h21, 1'b1);
        rbyte(8'h13, 1'b0);
        i2c_stop();

        // One-clock SCL glitch while receiving: must not count as a bit
        exp_wr.push_back({16'h5000, 16'h7766});
        i2c_start();
        wbyte(8'h20, 1'b1);
        tick(2);
        m_scl = 1'b1;
        tick(1);
        m_scl = 1'b0;
        wbyte(8'h50, 1'b1);
        wbyte(8'h00, 1'b1);
        wbyte(8'h77, 1'b1);
        wbyte(8'h66, 1'b1);
        i2c_stop();

        tick(50);
        check("pending wr expectations", exp_wr.size(), 32'd0);
        check("pending rd expectations", exp_rd.size(), 32'd0);
        check("pending bus expectations", exp_bus.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_reg16_slave.md
I2C_REG16_SLAVE -- requirements
Module: i2c_reg16_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h10, the 7-bit device address it responds to (8-bit write address 0x20).
REQ-002 SHALL have parameter FILT_LEN, default 3, the number of consecutive equal clk samples required to accept a new SCL/SDA level.
REQ-003 clk  input  1  system clock; SCL is oversampled with at least 8 clk per SCL period.
REQ-004 rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-005 scl_i  input  1  I2C clock from the bus, asynchronous to clk.
REQ-006 sda_i  input  1  I2C data from the bus, asynchronous to clk.
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
REQ-008 wr_en  output  1  one-clk register-write strobe.
REQ-009 wr_addr  output  16  register address, valid while wr_en=1.
REQ-010 wr_data  output  16  register data, valid while wr_en=1.
REQ-011 rd_req  output  1  one-clk read request for the address on rd_addr.
REQ-012 rd_addr  output  16  register address, valid while rd_req=1.
REQ-013 rd_data  input  16  read data; sampled exactly 1 clk after rd_req.
REQ-014 busy  output  1  1 from an accepted address match until STOP or a non-matching address.

Function
REQ-015 scl_i and sda_i SHALL each pass through a 2-flop synchronizer, then a FILT_LEN-sample glitch filter; all logic uses only the filtered levels.
REQ-016 START SHALL be detected on SDA falling while SCL=1, and STOP on SDA rising while SCL=1; both are honoured in every state.
REQ-017 Data bits SHALL be sampled on filtered SCL rising edges, MSB first; sda_oe SHALL change only in the clk cycle after a filtered SCL falling edge.
REQ-018 States: IDLE, DEV, DEV_ACK, RA_HI, RA_LO, W_HI, W_LO, R_HI, R_LO, SLV_ACK, MST_ACK, IGNORE.
REQ-019 IDLE -> DEV on START; after 8 bits, if bits[7:1]==SLAVE_ADDR go to DEV_ACK, else go to IGNORE with SDA released.
REQ-020 DEV_ACK: drive sda_oe=1 for the 9th bit; if R/W=0 go to RA_HI, else go to R_HI using the current address pointer.
REQ-021 RA_HI and RA_LO SHALL each receive one byte with an ACK, loading the 16-bit address pointer {hi,lo}; then go to W_HI.
REQ-022 W_HI and W_LO SHALL each receive one byte with an ACK; on the 8th SCL rise of W_LO, pulse wr_en with wr_addr=pointer and wr_data={hi,lo}, then pointer += 2 (mod 2^16) and return to W_HI.
REQ-023 A repeated START in any state SHALL return to DEV; the address pointer SHALL be retained, so write-address-then-repeated-START-read works.
REQ-024 On entering R_HI, pulse rd_req with rd_addr=pointer and latch rd_data 1 clk later; shift out hi then lo, releasing SDA for each 1 bit; MST_ACK samples the master bit after each byte.
REQ-025 After R_LO, pointer += 2. A master ACK continues to the next R_HI (new rd_req); a NACK goes to IGNORE.
REQ-026 A STOP SHALL go to IDLE and release SDA; a partial byte or partial word is discarded with no wr_en.
REQ-027 IGNORE SHALL keep sda_oe=0 until START or STOP.
REQ-028 wr_en and rd_req SHALL never assert in the same cycle, and each SHALL be exactly 1 clk wide.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE; sda_oe=0; wr_en=0; rd_req=0; busy=0; wr_addr, wr_data, rd_addr and pointer=0; filters and synchronizers set to 1 (idle bus).
REQ-030 After rst deasserts, no START SHALL be recognised until the filtered SCL and SDA have both been 1 for FILT_LEN clk.

Verification
REQ-031 Write 0x20,0x30,0x1A,0x10,0xDC,STOP -> five ACKs; one wr_en with wr_addr=0x301A and wr_data=0x10DC.
REQ-032 Write 0x20,0x30,0x00, then repeated START 0x21, read 2 bytes with the master NACKing the last; rd_data=0x0554 -> one rd_req with rd_addr=0x3000; bus bytes 0x05,0x54.
REQ-033 Burst write to 0x302C of data 0x0001,0x0008 -> wr_en at 0x302C/0x0001, then at 0x302E/0x0008.
REQ-034 Address byte 0x22 -> no ACK, sda_oe stays 0, no strobes, busy=0.
REQ-035 STOP after 4 bits of W_LO, and separately rst asserted mid-R_HI -> no wr_en; sda_oe=0 within 1 clk of rst; next transaction is accepted normally.
REQ-036 A 1-clk glitch on SCL with FILT_LEN=3 -> no bit sampled and no state change.
